ir_pointer: RTL and testbench

IR_POINTER -- requirements
Module: ir_pointer

---
 rtl/ir_pointer.sv | 166 ++++++++++++++++
 tb/tb_ir_pointer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_pointer.sv
// Instruction pointer sequencer with jump, wait-stall and halt control.
// Optional one-entry call/return register enabled by `define IR_PTR_STACK_EN.
module ir_pointer #(
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned RST_VECTOR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_ir_regfile_selection,
    input  logic                  i_jump_valid,
    input  logic [2:0]            i_jump_type,
    input  logic [DATA_WIDTH-1:0] i_jump_target,
    input  logic [DATA_WIDTH-1:0] i_cmp_a,
    input  logic [DATA_WIDTH-1:0] i_cmp_b,
    input  logic                  i_wait,
    input  logic [7:0]            i_wait_cycles,
    input  logic                  i_stop,
    input  logic                  i_fetch_ready,
    output logic [DATA_WIDTH-1:0] o_ir_pointer,
    output logic                  o_fetch_valid,
    output logic                  o_halted,
    output logic [2:0]            o_state
);

    localparam logic [DATA_WIDTH-1:0] RST_PTR = DATA_WIDTH'(RST_VECTOR);

    localparam logic [1:0] SEL_RST  = 2'b01;
    localparam logic [1:0] SEL_WORK = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_HALT = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  cond;
    logic                  work;
    logic [DATA_WIDTH-1:0] ptr_inc;
    logic [DATA_WIDTH-1:0] jump_dest;

`ifdef IR_PTR_STACK_EN
    logic [DATA_WIDTH-1:0] ret_q, ret_d;
`endif

    assign work    = (i_ir_regfile_selection == SEL_WORK);
    assign ptr_inc = ptr_q + 1'b1;

    always_comb begin
        cond = 1'b0;
        case (i_jump_type)
            3'd1:    cond = 1'b1;
            3'd2:    cond = (i_cmp_a > i_cmp_b);
            3'd3:    cond = (i_cmp_a < i_cmp_b);
            3'd4:    cond = (i_cmp_a == i_cmp_b);
            3'd5:    cond = (i_cmp_a != i_cmp_b);
            3'd6:    cond = 1'b1;
`ifdef IR_PTR_STACK_EN
            3'd7:    cond = 1'b1;
`else
            3'd7:    cond = 1'b0;
`endif
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        jump_dest = i_jump_target;
`ifdef IR_PTR_STACK_EN
        if (i_jump_type == 3'd7) begin
            jump_dest = ret_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
`ifdef IR_PTR_STACK_EN
        ret_d   = ret_q;
`endif
        // Controller reset selection overrides everything, in every state.
        if (i_ir_regfile_selection == SEL_RST) begin
            state_d = S_LOAD;
            ptr_d   = RST_PTR;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (work) state_d = S_RUN;
                end
                S_LOAD: begin
                    state_d = work ? S_RUN : S_IDLE;
                end
                S_RUN: begin
                    if (!work) begin
                        state_d = S_IDLE;
                    end else if (i_stop) begin
                        state_d = S_HALT;
                    end else if (i_jump_valid && cond) begin
                        ptr_d = jump_dest;
`ifdef IR_PTR_STACK_EN
                        if (i_jump_type == 3'd6) ret_d = ptr_inc;
`endif
                    end else if (i_wait && (i_wait_cycles != 8'd0)) begin
                        state_d = S_WAIT;
                        cnt_d   = i_wait_cycles;
                    end else if (i_fetch_ready) begin
                        ptr_d = ptr_inc;
                    end
                end
                S_WAIT: begin
                    if (!work) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        // Leaving on count 1 gives exactly N stalled cycles.
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q <= 8'd1) state_d = S_RUN;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_LOAD;
                    ptr_d   = RST_PTR;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            ptr_q   <= RST_PTR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef IR_PTR_STACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_q <= '0;
        end else begin
            ret_q <= ret_d;
        end
    end
`endif

    assign o_ir_pointer  = ptr_q;
    assign o_fetch_valid = (state_q == S_RUN);
    assign o_halted      = (state_q == S_HALT);
    assign o_state       = state_q;

endmodule

// File: tb/tb_ir_pointer.sv
// Random and directed checks of ir_pointer against a behavioural model.
// Honours IR_PTR_STACK_EN the same way as the design.
module tb_ir_pointer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b00;
    logic       jv = 1'b0;
    logic [2:0] jtype = 3'd0;
    logic [7:0] jtgt = 8'd0;
    logic [7:0] ca = 8'd0;
    logic [7:0] cb = 8'd0;
    logic       wt = 1'b0;
    logic [7:0] wcyc = 8'd0;
    logic       stp = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] ptr;
    logic       fv;
    logic       hlt;
    logic [2:0] st;

    int checks = 0;
    int failures = 0;

`ifdef IR_PTR_STACK_EN
    localparam bit STACK = 1'b1;
`else
    localparam bit STACK = 1'b0;
`endif

    // model: state number as listed for o_state, pointer and counters as ints
    int m_st = 1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_ret = 0;

    always #5 clk = ~clk;

    ir_pointer #(.DATA_WIDTH(8), .RST_VECTOR(0)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_ir_regfile_selection(sel),
        .i_jump_valid          (jv),
        .i_jump_type           (jtype),
        .i_jump_target         (jtgt),
        .i_cmp_a               (ca),
        .i_cmp_b               (cb),
        .i_wait                (wt),
        .i_wait_cycles         (wcyc),
        .i_stop                (stp),
        .i_fetch_ready         (rdy),
        .o_ir_pointer          (ptr),
        .o_fetch_valid         (fv),
        .o_halted              (hlt),
        .o_state               (st)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit taken();
        int a = int'(ca);
        int b = int'(cb);
        if (!jv) return 1'b0;
        case (int'(jtype))
            1: return 1'b1;
            2: return a > b;
            3: return a < b;
            4: return a == b;
            5: return a != b;
            6: return 1'b1;
            7: return STACK;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 1; m_ptr = 0; m_cnt = 0; m_ret = 0;
    endtask

    task automatic model_step();
        int old_ptr;
        if (rst) begin
            model_reset();
            return;
        end
        if (sel == 2'b01) begin
            m_st = 1; m_ptr = 0; m_cnt = 0;
            return;
        end
        case (m_st)
            0: if (sel == 2'b10) m_st = 2;
            1: m_st = (sel == 2'b10) ? 2 : 0;
            2: begin
                if (sel != 2'b10) m_st = 0;
                else if (stp) m_st = 4;
                else if (taken()) begin
                    old_ptr = m_ptr;
                    if (STACK && jtype == 3'd7) m_ptr = m_ret;
                    else m_ptr = int'(jtgt);
                    if (STACK && jtype == 3'd6) m_ret = (old_ptr + 1) % 256;
                end else if (wt && wcyc > 0) begin
                    m_st = 3; m_cnt = int'(wcyc);
                end else if (rdy) m_ptr = (m_ptr + 1) % 256;
            end
            3: begin
                if (sel != 2'b10) begin m_st = 0; m_cnt = 0; end
                else begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_st = 2;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
        chk({tag, ".state"}, 32'(st), 32'(m_st));
        chk({tag, ".fv"}, 32'(fv), 32'(m_st == 2));
        chk({tag, ".halt"}, 32'(hlt), 32'(m_st == 4));
    endtask

    // one clock: DUT and model advance on the edge, compare on the falling edge
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model(tag);
    endtask

    task automatic idle_inputs();
        jv = 1'b0; jtype = 3'd0; wt = 1'b0; wcyc = 8'd0; stp = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        cmp_model("reset");
        chk("reset.state_const", 32'(st), 32'd1);
        chk("reset.ptr_const", 32'(ptr), 32'd0);

        rst = 1'b0; sel = 2'b10; rdy = 1'b1;
        cycle("start");
        chk("start.fv", 32'(fv), 32'd1);
        chk("start.ptr0", 32'(ptr), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cycle("seq");
            chk("seq.ptr", 32'(ptr), 32'(i));
        end

        jv = 1'b1; jtype = 3'd1; jtgt = 8'hFF; rdy = 1'b0;
        cycle("to_ff");
        chk("to_ff.ptr", 32'(ptr), 32'hFF);
        jv = 1'b0; rdy = 1'b1;
        cycle("wrap");
        chk("wrap.ptr", 32'(ptr), 32'h00);

        jv = 1'b1; jtype = 3'd2; ca = 8'd5; cb = 8'd3; jtgt = 8'h40; rdy = 1'b0;
        cycle("gt_taken");
        chk("gt_taken.ptr", 32'(ptr), 32'h40);
        ca = 8'd3; jtgt = 8'h55;
        cycle("gt_not");
        chk("gt_not.ptr", 32'(ptr), 32'h40);

        idle_inputs(); wt = 1'b1; wcyc = 8'd3; rdy = 1'b1;
        cycle("wait0");
        chk("wait0.fv", 32'(fv), 32'd0);
        wt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle("wait_n");
            chk("wait_n.fv", 32'(fv), 32'd0);
        end
        rdy = 1'b0;
        cycle("wait_end");
        chk("wait_end.fv", 32'(fv), 32'd1);
        chk("wait_end.ptr", 32'(ptr), 32'h40);

        stp = 1'b1; jv = 1'b1; jtype = 3'd1; jtgt = 8'h99;
        cycle("halt");
        chk("halt.o_halted", 32'(hlt), 32'd1);
        chk("halt.ptr", 32'(ptr), 32'h40);
        idle_inputs(); rdy = 1'b1;
        cycle("halt_hold");
        sel = 2'b01;
        cycle("halt_exit");
        chk("halt_exit.state", 32'(st), 32'd1);
        chk("halt_exit.ptr", 32'(ptr), 32'd0);

        sel = 2'b10; rdy = 1'b0;
        cycle("run2");
        jv = 1'b1; jtype = 3'd1; jtgt = 8'h10;
        cycle("to_10");
        jtype = 3'd6; jtgt = 8'h80;
        cycle("call");
        chk("call.ptr", 32'(ptr), 32'h80);
        jtype = 3'd7; jtgt = 8'h33; rdy = 1'b1;
        cycle("ret");
        chk("ret.ptr", 32'(ptr), STACK ? 32'h11 : 32'h81);

        idle_inputs(); wt = 1'b1; wcyc = 8'd4;
        cycle("wait_rst");
        wt = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.state", 32'(st), 32'd1);
        chk("async_rst.ptr", 32'(ptr), 32'd0);
        chk("async_rst.fv", 32'(fv), 32'd0);
        cycle("rst_hold");
        rst = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            sel = (r < 3) ? 2'b01 : (r < 8) ? 2'(r & 1) * 2'b11 : 2'b10;
            jv = ($urandom_range(0, 2) == 0);
            jtype = 3'($urandom_range(0, 7));
            jtgt = 8'($urandom);
            ca = 8'($urandom_range(0, 3));
            cb = 8'($urandom_range(0, 3));
            wt = ($urandom_range(0, 9) == 0);
            wcyc = 8'($urandom_range(0, 4));
            stp = ($urandom_range(0, 49) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
